// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller: shadow-buffered hex value, per-slot
// ghosting guard, optional leading-zero blanking and a four-phase load handshake.
module seven_seg_scan_ctrl #(
    parameter int DIGITS    = 4,
    parameter int SLOT_CYC  = 50000,
    parameter int GUARD_CYC = 16
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  enable,
    input  logic                  load_req,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  blank_lz,
    output logic                  load_ack,
    output logic [3:0]            nibble,
    output logic [DIGITS-1:0]     digit_en_n,
    output logic                  frame_done
);

    localparam int CW = $clog2(SLOT_CYC);
    localparam int IW = $clog2(DIGITS);
    localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYC - 1);
    localparam logic [CW-1:0] SLOT_LAST  = CW'(SLOT_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    typedef enum logic [1:0] {
        PARK,
        GUARD,
        DRIVE
    } state_t;

    state_t                state, state_nxt;
    logic [CW-1:0]         cnt, cnt_nxt;
    logic [IW-1:0]         idx, idx_nxt;
    logic [4*DIGITS-1:0]   shadow, shadow_nxt;
    logic                  blz, blz_nxt;
    logic                  armed;
    logic                  frame_end_nxt;
    logic                  ack_nxt;
    logic [DIGITS-1:0]     blank;
    logic                  zero_above;
    logic [DIGITS-1:0]     en_nxt;
    logic [3:0]            nibble_nxt;

    // Scan sequencer: every output below is derived from these next-state values
    // and then registered, so outputs line up with the state they describe.
    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        case (state)
            PARK: begin
                if (enable) begin
                    state_nxt = GUARD;
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                end
            end
            GUARD: begin
                cnt_nxt = cnt + 1'b1;
                if (cnt == GUARD_LAST) state_nxt = DRIVE;
            end
            DRIVE: begin
                if (cnt == SLOT_LAST) begin
                    cnt_nxt   = '0;
                    idx_nxt   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
                    state_nxt = enable ? GUARD : PARK;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = PARK;
        endcase
    end

    // The ack is scheduled one cycle ahead so it lands on the frame-end cycle
    // (or a parked cycle); the shadow is written at the end of that ack cycle.
    always_comb begin
        frame_end_nxt = (state_nxt == DRIVE) && (cnt_nxt == SLOT_LAST) && (idx_nxt == IDX_LAST);
        ack_nxt       = load_req && armed && (frame_end_nxt || (state_nxt == PARK));
        shadow_nxt    = load_ack ? value : shadow;
        blz_nxt       = load_ack ? blank_lz : blz;
    end

    always_comb begin
        blank      = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above && (shadow_nxt[4*i +: 4] == 4'h0);
            blank[i]   = blz_nxt && zero_above;
        end
    end

    always_comb begin
        en_nxt = '1;
        if (state_nxt == DRIVE && !blank[idx_nxt]) en_nxt[idx_nxt] = 1'b0;
        nibble_nxt = nibble;
        if (state_nxt == GUARD && cnt_nxt == '0) nibble_nxt = shadow_nxt[4*idx_nxt +: 4];
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge clk or negedge clr) begin
        // NOTE: the shadow is an ordinary register bank, so it is cleared by reset like all other state.
        if (!clr) begin
            state      <= PARK;
            cnt        <= '0;
            idx        <= '0;
            shadow     <= '0;
            blz        <= 1'b0;
            armed      <= 1'b1;
            load_ack   <= 1'b0;
            frame_done <= 1'b0;
            nibble     <= 4'h0;
            digit_en_n <= '1;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            shadow     <= shadow_nxt;
            blz        <= blz_nxt;
            armed      <= !load_req ? 1'b1 : (ack_nxt ? 1'b0 : armed);
            load_ack   <= ack_nxt;
            frame_done <= frame_end_nxt;
            nibble     <= nibble_nxt;
            digit_en_n <= en_nxt;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl with a short slot (8 cycles, 2 guard)
// so whole frames of enables, nibbles and handshake pulses can be checked cycle by cycle.
module tb_seven_seg_scan_ctrl;

    localparam int DIGITS    = 4;
    localparam int SLOT_CYC  = 8;
    localparam int GUARD_CYC = 2;

    logic          clk;
    logic          clr;
    logic          enable;
    logic          load_req;
    logic [15:0]   value;
    logic          blank_lz;
    logic          load_ack;
    logic [3:0]    nibble;
    logic [3:0]    digit_en_n;
    logic          frame_done;

    int checks;
    int errors;

    seven_seg_scan_ctrl #(
        .DIGITS    (DIGITS),
        .SLOT_CYC  (SLOT_CYC),
        .GUARD_CYC (GUARD_CYC)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .enable     (enable),
        .load_req   (load_req),
        .value      (value),
        .blank_lz   (blank_lz),
        .load_ack   (load_ack),
        .nibble     (nibble),
        .digit_en_n (digit_en_n),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Entered at the negedge of cycle 0 of a frame (first GUARD cycle of digit 0);
    // leaves at the negedge of cycle 0 of the following frame.
    task automatic check_frame(input logic [15:0] shown, input logic [3:0] mask,
                               input logic exp_ack, input string tag);
        logic [3:0] exp_en;
        logic [3:0] exp_nib;
        for (int d = 0; d < DIGITS; d++) begin
            exp_nib = shown[4*d +: 4];
            for (int c = 0; c < SLOT_CYC; c++) begin
                exp_en = 4'hF;
                if (c >= GUARD_CYC && mask[d]) exp_en[d] = 1'b0;
                check($sformatf("%s en d%0d c%0d", tag, d, c), digit_en_n, exp_en);
                check($sformatf("%s nib d%0d c%0d", tag, d, c), nibble, exp_nib);
                check($sformatf("%s fd d%0d c%0d", tag, d, c), frame_done,
                      (d == DIGITS - 1 && c == SLOT_CYC - 1));
                check($sformatf("%s ack d%0d c%0d", tag, d, c), load_ack,
                      (exp_ack && d == DIGITS - 1 && c == SLOT_CYC - 1));
                @(negedge clk);
            end
        end
    endtask

    task automatic park_load(input logic [15:0] v, input logic b);
        bit seen;
        value    = v;
        blank_lz = b;
        load_req = 1'b1;
        seen     = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = load_ack;
        end
        check("park ack seen", seen, 1'b1);
        load_req = 1'b0;
        @(negedge clk);
        check("park ack one pulse", load_ack, 1'b0);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        clr      = 1'b0;
        enable   = 1'b0;
        load_req = 1'b0;
        value    = 16'h0;
        blank_lz = 1'b0;
        repeat (3) @(negedge clk);
        check("rst en", digit_en_n, 4'hF);
        check("rst nib", nibble, 4'h0);
        check("rst ack", load_ack, 1'b0);
        check("rst fd", frame_done, 1'b0);
        clr = 1'b1;
        repeat (2) @(negedge clk);
        check("park en", digit_en_n, 4'hF);

        // Basic scan of 1A3F.
        park_load(16'h1A3F, 1'b0);
        enable = 1'b1;
        @(negedge clk);
        check_frame(16'h1A3F, 4'hF, 1'b0, "f1");
        check_frame(16'h1A3F, 4'hF, 1'b0, "f2");

        // Mid-frame load request: ack on frame end, old value until the wrap, no second ack.
        value    = 16'h0042;
        blank_lz = 1'b1;
        load_req = 1'b1;
        check_frame(16'h1A3F, 4'hF, 1'b1, "ld42");
        check_frame(16'h0042, 4'h3, 1'b0, "hold");
        load_req = 1'b0;
        blank_lz = 1'b0;
        check_frame(16'h0042, 4'h3, 1'b0, "nosample");
        load_req = 1'b1;
        check_frame(16'h0042, 4'h3, 1'b1, "ld42nb");
        load_req = 1'b0;
        check_frame(16'h0042, 4'hF, 1'b0, "noblank");

        // All-zero value with blanking: only digit 0 lit.
        value    = 16'h0000;
        blank_lz = 1'b1;
        load_req = 1'b1;
        check_frame(16'h0042, 4'hF, 1'b1, "ld0");
        load_req = 1'b0;
        check_frame(16'h0000, 4'h1, 1'b0, "zero");

        value    = 16'h1A3F;
        blank_lz = 1'b0;
        load_req = 1'b1;
        check_frame(16'h0000, 4'h1, 1'b1, "ld1a");
        load_req = 1'b0;

        // Drop enable mid-DRIVE of digit 2: slot completes, then park.
        repeat (2 * SLOT_CYC + GUARD_CYC + 2) @(negedge clk);
        enable = 1'b0;
        for (int c = 4; c < SLOT_CYC; c++) begin
            check($sformatf("d2 finish c%0d", c), digit_en_n, 4'b1011);
            @(negedge clk);
        end
        for (int c = 0; c < 10; c++) begin
            check($sformatf("parked en %0d", c), digit_en_n, 4'hF);
            check($sformatf("parked fd %0d", c), frame_done, 1'b0);
            @(negedge clk);
        end
        enable = 1'b1;
        @(negedge clk);
        check_frame(16'h1A3F, 4'hF, 1'b0, "restart");

        // Async reset mid-DRIVE of digit 1.
        repeat (SLOT_CYC + GUARD_CYC) @(negedge clk);
        check("pre clr en", digit_en_n, 4'b1101);
        clr = 1'b0;
        #1;
        check("clr async en", digit_en_n, 4'hF);
        check("clr async nib", nibble, 4'h0);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        check_frame(16'h0000, 4'hF, 1'b0, "postclr");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_ctrl.md
SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

Interface
REQ-001 Parameter DIGITS, default 4, number of multiplexed digits; legal range 2..8.
REQ-002 Parameter SLOT_CYC, default 50000, clock cycles per digit slot, including guard time; minimum GUARD_CYC+2.
REQ-003 Parameter GUARD_CYC, default 16, cycles at the start of each slot with all digits disabled (ghosting guard).
REQ-004 Port clk  input  1  single system clock; all state updates on posedge.
REQ-005 Port clr  input  1  asynchronous active-low reset.
REQ-006 Port enable  input  1  1 = scanning runs; 0 = scanner parks at the next slot boundary.
REQ-007 Port load_req  input  1  request to update the displayed value; held until load_ack.
REQ-008 Port value  input  4*DIGITS  hex value to display; digit 0 = bits [3:0] (rightmost); sampled only when load_ack is asserted.
REQ-009 Port blank_lz  input  1  1 = suppress leading zero digits; sampled with value.
REQ-010 Port load_ack  output  1  one-cycle pulse; value is captured into the shadow register in that cycle.
REQ-011 Port nibble  output  4  hex code for the active digit; drives the data input of the 4-bit-to-7-segment decoder.
REQ-012 Port digit_en_n  output  DIGITS  active-low digit (common-anode) enables; at most one bit low at any time.
REQ-013 Port frame_done  output  1  one-cycle pulse at the end of the last digit's slot.

Function
REQ-014 Shadow register: 4*DIGITS bits plus a latched blank_lz bit; the display shows the shadow only, never value directly.
REQ-015 States: PARK (all enables high), GUARD (all enables high, nibble already set for the upcoming digit), DRIVE (one enable low).
REQ-016 Slot counter: 0..SLOT_CYC-1; the slot is in GUARD for counts 0..GUARD_CYC-1 and in DRIVE for the remaining counts.
REQ-017 Digit index: 0..DIGITS-1; it increments at each slot end and wraps from DIGITS-1 to 0, and frame_done pulses on that wrap cycle.
REQ-018 PARK->GUARD: entered on the first cycle with enable=1; the digit index and slot counter start at 0.
REQ-019 GUARD->DRIVE: when the slot counter reaches GUARD_CYC. DRIVE->GUARD: at the slot end while enable=1. DRIVE->PARK: at the slot end while enable=0.
REQ-020 In DRIVE, digit_en_n[i] is low exactly when i equals the digit index and that digit is not blanked.
REQ-021 Blanking, when the latched blank_lz is 1: digit i is blanked if its shadow nibble and all higher shadow nibbles are 0. Digit 0 is never blanked, so a value of 0 shows as "0".
REQ-022 nibble = shadow[4*idx+3:4*idx]; it changes only on the first GUARD cycle of a slot.
REQ-023 load_ack is asserted in the same cycle as frame_done when load_req=1; in PARK it is asserted on the first cycle that load_req=1. A frame is never torn.
REQ-024 After load_ack, a new ack requires load_req to be seen low for at least one cycle (four-phase handshake).
REQ-025 If load_req and enable=0 arrive at the same frame end, the load is taken and then the scanner parks.
REQ-026 The outputs of this block are glitch-free registered outputs; there are no combinational paths from inputs to outputs.

Reset
REQ-027 While clr=0: state=PARK, slot counter=0, index=0, shadow=0, latched blank_lz=0, nibble=0, digit_en_n=all ones, load_ack=0, frame_done=0.
REQ-028 Reset asserted mid-slot immediately forces all enables high, with no partial-slot completion. After clr deasserts, the first slot starts with GUARD.

Verification
REQ-029 DIGITS=4, SLOT_CYC=8, GUARD_CYC=2; reset; then enable=1 with shadow loaded to 16'h1A3F -> digit_en_n sequence 1111 x2, 1110 x6, 1111 x2, 1101 x6, and so on. nibble sequence is F, 3, A, 1. frame_done pulses every 32 cycles.
REQ-030 Load 16'h0042 with blank_lz=1 -> digits 3 and 2 never enabled, digits 1 and 0 show 4 and 2. With blank_lz=0, all four digits are enabled.
REQ-031 Load 16'h0000 with blank_lz=1 -> only digit 0 is enabled, showing 0.
REQ-032 Raise load_req mid-frame -> load_ack coincides with frame_done; the old value is shown until the wrap; holding load_req high yields no second ack.
REQ-033 Drop enable mid-DRIVE of digit 2 -> digit 2 completes its slot, then all enables are high. Reassert enable -> scanning restarts at digit 0 with GUARD.
REQ-034 Pulse clr low for 1 cycle mid-DRIVE -> digit_en_n=1111 asynchronously, before the next clk edge, and the shadow is cleared to 0.
